// File: rtl/tdc_enc_pkg.sv
// tdc_enc_pkg: shared TDC encoder widths, default level and round-robin pick helper
package tdc_enc_pkg;
  localparam int THERM_W = 8;
  localparam int BIN_W = 3;
  localparam logic [2:0] LEVEL_DEFAULT = 3'd1;
  localparam int RR_MAX = 16;
  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_pick_t;
  // First set request at or above ptr, wrapping modulo n; later loop passes win, so scan downward
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req, input logic [3:0] ptr, input int n);
    rr_pick_t r;
    int j;
    r = '0;
    for (int i = RR_MAX - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % n;
      if (i < n && req[j]) r = '{found: 1'b1, idx: 4'(j)};
    end
    return r;
  endfunction
endpackage

// File: rtl/tdc_enc_arbiter_encode8b3b.sv
// encode8b3b: bubble-tolerant 8b thermometer to 3b fine-time encoder
module encode8b3b
  import tdc_enc_pkg::*;
(
  input  logic [THERM_W-1:0] code,
  input  logic [2:0]         lvl,
  output logic [BIN_W-1:0]   bin,
  output logic               bubble,
  output logic               err
);
  logic [2:0] l, r, span, eff;
  always_comb begin
    l = 3'd7;
    for (int i = THERM_W - 1; i >= 0; i--) if (code[i]) l = 3'(i);
    r = 3'd0;
    for (int i = 0; i < THERM_W; i++) if (code[i]) r = 3'(i);
    span = r - l;
    eff = lvl == 3'd0 ? LEVEL_DEFAULT : lvl;
    err = span >= eff;
    bubble = span != 3'd0;
    bin = err ? 3'd0 : span <= 3'd1 ? l : l + 3'd1;
  end
endmodule

// File: rtl/tdc_enc_arbiter.sv
// tdc_enc_arbiter: round-robin sharing of one encode8b3b across NCH channels with stats
module tdc_enc_arbiter
  import tdc_enc_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CNTW = 16,
  localparam int CHW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           level_i,
  input  logic [NCH-1:0]       ch_valid,
  input  logic [8*NCH-1:0]     ch_code,
  output logic [NCH-1:0]       ch_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CHW-1:0]       out_ch,
  output logic [BIN_W-1:0]     out_bin,
  output logic                 out_bubble,
  output logic                 out_err,
  input  logic                 cnt_clr,
  output logic [CNTW-1:0]      bubble_cnt,
  output logic [CNTW-1:0]      err_cnt
);
  rr_pick_t pick;
  logic [CHW-1:0] idx, ptr_q, ptr_d, out_ch_q, out_ch_d;
  logic [THERM_W-1:0] code;
  logic [BIN_W-1:0] enc_bin, out_bin_q, out_bin_d;
  logic enc_bubble, enc_err, can_load, xfer;
  logic out_valid_q, out_valid_d, out_bubble_q, out_bubble_d, out_err_q, out_err_d;
  logic [CNTW-1:0] bubble_cnt_q, bubble_cnt_d, err_cnt_q, err_cnt_d;
  encode8b3b u_enc (.code(code), .lvl(level_i), .bin(enc_bin), .bubble(enc_bubble), .err(enc_err));
  // rst_n gating keeps ch_ready low during reset even though can_load is already true
  always_comb begin
    pick = rr_pick(RR_MAX'(ch_valid), 4'(ptr_q), NCH);
    idx = CHW'(pick.idx);
    can_load = !out_valid_q | out_ready;
    xfer = pick.found & can_load & rst_n;
    ch_ready = xfer ? NCH'(1) << idx : '0;
    code = ch_code[idx*THERM_W +: THERM_W];
    out_valid_d = xfer | (out_valid_q & !out_ready);
    out_ch_d = xfer ? idx : out_ch_q;
    out_bin_d = xfer ? enc_bin : out_bin_q;
    out_bubble_d = xfer ? enc_bubble : out_bubble_q;
    out_err_d = xfer ? enc_err : out_err_q;
    ptr_d = !xfer ? ptr_q : idx == CHW'(NCH - 1) ? '0 : idx + 1'b1;
    bubble_cnt_d = cnt_clr ? '0 : (xfer & enc_bubble & ~&bubble_cnt_q) ? bubble_cnt_q + 1'b1 : bubble_cnt_q;
    err_cnt_d = cnt_clr ? '0 : (xfer & enc_err & ~&err_cnt_q) ? err_cnt_q + 1'b1 : err_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_ch_q <= '0;
      out_bin_q <= '0;
      out_bubble_q <= 1'b0;
      out_err_q <= 1'b0;
      ptr_q <= '0;
      bubble_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_ch_q <= out_ch_d;
      out_bin_q <= out_bin_d;
      out_bubble_q <= out_bubble_d;
      out_err_q <= out_err_d;
      ptr_q <= ptr_d;
      bubble_cnt_q <= bubble_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_ch = out_ch_q;
  assign out_bin = out_bin_q;
  assign out_bubble = out_bubble_q;
  assign out_err = out_err_q;
  assign bubble_cnt = bubble_cnt_q;
  assign err_cnt = err_cnt_q;
endmodule

// File: tb/tb_tdc_enc_arbiter.sv
// tb_tdc_enc_arbiter: directed vector table plus saturation and mid-stream reset sequences
module tb_tdc_enc_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [2:0] level_i = 3'd2;
  logic [3:0] ch_valid = 4'h0;
  logic [31:0] ch_code = 32'h0;
  logic [3:0] ch_ready;
  logic out_valid, out_ready = 1'b1, out_bubble, out_err, cnt_clr = 1'b0;
  logic [1:0] out_ch;
  logic [2:0] out_bin;
  logic [3:0] bubble_cnt, err_cnt;
  int n_cmp = 0;
  int n_bad = 0;

  tdc_enc_arbiter #(.NCH(4), .CNTW(4)) dut (
    .clk(clk), .rst_n(rst_n), .level_i(level_i), .ch_valid(ch_valid), .ch_code(ch_code),
    .ch_ready(ch_ready), .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_bin(out_bin), .out_bubble(out_bubble), .out_err(out_err), .cnt_clr(cnt_clr),
    .bubble_cnt(bubble_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  vld;
    logic [31:0] code;
    logic [2:0]  lvl;
    logic        ordy;
    logic        clr;
    logic [3:0]  rdy;
    logic        v;
    logic [1:0]  ch;
    logic [2:0]  bin;
    logic        bub;
    logic        err;
    logic [3:0]  bc;
    logic [3:0]  ec;
  } vec_t;
  vec_t tv[26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    tv[0]  = '{4'h0, 32'h0000_0000, 3'd2, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 4'd0, 4'd0};
    tv[1]  = '{4'h2, 32'h0000_0F00, 3'd2, 1'b1, 1'b0, 4'h2, 1'b1, 2'd1, 3'd0, 1'b1, 1'b1, 4'd1, 4'd1};
    tv[2]  = '{4'h2, 32'h0000_0100, 3'd2, 1'b1, 1'b0, 4'h2, 1'b1, 2'd1, 3'd0, 1'b0, 1'b0, 4'd1, 4'd1};
    tv[3]  = '{4'hF, 32'h0680_1001, 3'd3, 1'b1, 1'b0, 4'h4, 1'b1, 2'd2, 3'd7, 1'b0, 1'b0, 4'd1, 4'd1};
    tv[4]  = '{4'hF, 32'h0680_1001, 3'd3, 1'b1, 1'b0, 4'h8, 1'b1, 2'd3, 3'd1, 1'b1, 1'b0, 4'd2, 4'd1};
    tv[5]  = '{4'hF, 32'h0680_1001, 3'd3, 1'b1, 1'b0, 4'h1, 1'b1, 2'd0, 3'd0, 1'b0, 1'b0, 4'd2, 4'd1};
    tv[6]  = '{4'hF, 32'h0680_1001, 3'd3, 1'b1, 1'b0, 4'h2, 1'b1, 2'd1, 3'd4, 1'b0, 1'b0, 4'd2, 4'd1};
    tv[7]  = '{4'hF, 32'h0680_1001, 3'd3, 1'b1, 1'b0, 4'h4, 1'b1, 2'd2, 3'd7, 1'b0, 1'b0, 4'd2, 4'd1};
    for (int i = 8; i < 13; i++)
      tv[i] = '{4'hF, 32'h0680_1001, 3'd3, 1'b0, 1'b0, 4'h0, 1'b1, 2'd2, 3'd7, 1'b0, 1'b0, 4'd2, 4'd1};
    tv[13] = '{4'hF, 32'h0680_1001, 3'd3, 1'b1, 1'b0, 4'h8, 1'b1, 2'd3, 3'd1, 1'b1, 1'b0, 4'd3, 4'd1};
    tv[14] = '{4'h0, 32'h0680_1001, 3'd3, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 4'd3, 4'd1};
    tv[15] = '{4'h0, 32'h0000_0000, 3'd2, 1'b1, 1'b1, 4'h0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 4'd0, 4'd0};
    tv[16] = '{4'h1, 32'h0000_0005, 3'd2, 1'b1, 1'b0, 4'h1, 1'b1, 2'd0, 3'd0, 1'b1, 1'b1, 4'd1, 4'd1};
    tv[17] = '{4'h1, 32'h0000_0003, 3'd2, 1'b1, 1'b0, 4'h1, 1'b1, 2'd0, 3'd0, 1'b1, 1'b0, 4'd2, 4'd1};
    tv[18] = '{4'h1, 32'h0000_0000, 3'd2, 1'b1, 1'b0, 4'h1, 1'b1, 2'd0, 3'd7, 1'b1, 1'b0, 4'd3, 4'd1};
    tv[19] = '{4'h1, 32'h0000_0003, 3'd0, 1'b1, 1'b0, 4'h1, 1'b1, 2'd0, 3'd0, 1'b1, 1'b1, 4'd4, 4'd2};
    tv[20] = '{4'h1, 32'h0000_001C, 3'd3, 1'b1, 1'b0, 4'h1, 1'b1, 2'd0, 3'd3, 1'b1, 1'b0, 4'd5, 4'd2};
    tv[21] = '{4'h1, 32'h0000_003C, 3'd5, 1'b1, 1'b0, 4'h1, 1'b1, 2'd0, 3'd3, 1'b1, 1'b0, 4'd6, 4'd2};
    tv[22] = '{4'h1, 32'h0000_000C, 3'd4, 1'b1, 1'b0, 4'h1, 1'b1, 2'd0, 3'd2, 1'b1, 1'b0, 4'd7, 4'd2};
    tv[23] = '{4'h1, 32'h0000_0081, 3'd7, 1'b1, 1'b0, 4'h1, 1'b1, 2'd0, 3'd0, 1'b1, 1'b1, 4'd8, 4'd3};
    tv[24] = '{4'h1, 32'h0000_00F0, 3'd3, 1'b1, 1'b0, 4'h1, 1'b1, 2'd0, 3'd0, 1'b1, 1'b1, 4'd9, 4'd4};
    tv[25] = '{4'h1, 32'h0000_00F0, 3'd3, 1'b1, 1'b1, 4'h1, 1'b1, 2'd0, 3'd0, 1'b1, 1'b1, 4'd0, 4'd0};

    ch_valid = 4'hF;
    #2 rst_n = 1'b0;
    #1;
    chk("rst ch_ready", 32'(ch_ready), 32'h0);
    chk("rst out_valid", 32'(out_valid), 32'h0);
    chk("rst outs", {out_ch, out_bin, out_bubble, out_err}, 32'h0);
    chk("rst counters", {bubble_cnt, err_cnt}, 32'h0);
    ch_valid = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 26; i++) begin
      ch_valid = tv[i].vld;
      ch_code = tv[i].code;
      level_i = tv[i].lvl;
      out_ready = tv[i].ordy;
      cnt_clr = tv[i].clr;
      #1;
      chk($sformatf("v%0d ch_ready", i), 32'(ch_ready), 32'(tv[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(tv[i].v));
      if (tv[i].v) begin
        chk($sformatf("v%0d out_ch", i), 32'(out_ch), 32'(tv[i].ch));
        chk($sformatf("v%0d out_bin", i), 32'(out_bin), 32'(tv[i].bin));
        chk($sformatf("v%0d out_bubble", i), 32'(out_bubble), 32'(tv[i].bub));
        chk($sformatf("v%0d out_err", i), 32'(out_err), 32'(tv[i].err));
      end
      chk($sformatf("v%0d bubble_cnt", i), 32'(bubble_cnt), 32'(tv[i].bc));
      chk($sformatf("v%0d err_cnt", i), 32'(err_cnt), 32'(tv[i].ec));
      @(negedge clk);
    end

    cnt_clr = 1'b0;
    ch_valid = 4'h1;
    ch_code = 32'h0000_0003;
    level_i = 3'd2;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("sat bubble_cnt", 32'(bubble_cnt), 32'hF);
    chk("sat err_cnt", 32'(err_cnt), 32'h0);
    chk("sat out_valid", 32'(out_valid), 32'h1);

    @(negedge clk);
    ch_valid = 4'h2;
    ch_code = 32'h0000_0100;
    @(posedge clk);
    #1;
    chk("pre-rst out_ch", 32'(out_ch), 32'h1);
    @(negedge clk);
    ch_valid = 4'hF;
    ch_code = 32'h0680_1001;
    out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(out_valid), 32'h0);
    chk("midrst ch_ready", 32'(ch_ready), 32'h0);
    out_ready = 1'b1;
    #1;
    chk("midrst ch_ready rdy", 32'(ch_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-rst ch_ready", 32'(ch_ready), 32'h1);
    @(posedge clk);
    #1;
    chk("post-rst out_valid", 32'(out_valid), 32'h1);
    chk("post-rst out_ch", 32'(out_ch), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
